// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with IDLE/SHIFT/DONE control.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic h1, g1, s_bit, c_next, last_bit;

  // Two half-adder stages around the carry flop form one full-adder bit slice.
  always_comb begin
    h1       = ra[0] ^ rb[0];
    g1       = ra[0] & rb[0];
    s_bit    = h1 ^ carry;
    c_next   = g1 | (h1 & carry);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          res   <= {s_bit, res[WIDTH-1:1]};
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            // Final bit: publish the assembled result together with the carry.
            sum   <= {s_bit, res[WIDTH-1:1]};
            cout  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ c_next;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8).
// Define SERIAL_ADDER_OVF_EN for both files to also check the ovf flag.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] last_sum = 8'h00;
  logic       last_cout = 1'b0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation from an IDLE negedge; optional stray starts in SHIFT and DONE.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input bit inject);
    start = 1'b1; a = va; b = vb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'hA5; b = 8'h3C;
    check("busy_e0", busy, 1);
    check("done_e0", done, 0);
    for (int i = 1; i < 8; i++) begin
      if (inject && i == 3) begin start = 1'b1; a = 8'h01; b = 8'h01; end
      if (inject && i == 4) begin start = 1'b0; end
      @(negedge clk);
      check("busy_shift", busy, 1);
      check("done_shift", done, 0);
      check("sum_hold", sum, last_sum);
      check("cout_hold", cout, last_cout);
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("sum", sum, es);
    check("cout", cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", ovf, eo);
`else
    if (eo) begin end
`endif
    last_sum = es; last_cout = ec;
    if (inject) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_off", done, 0);
    check("busy_idle", busy, 0);
    check("sum_keep", sum, es);
    if (inject) begin
      @(negedge clk);
      check("ignored_start", busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(8'hC3, 8'h5A, 8'h1D, 1'b1, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);

    // Start held high: a result every 10 cycles.
    start = 1'b1; a = 8'h55; b = 8'hAA;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("held_done", done, (k % 10) == 8);
      if (done) begin
        check("held_sum", sum, 8'hFF);
        check("held_cout", cout, 0);
      end
      if (k == 29) start = 1'b0;
    end
    last_sum = 8'hFF; last_cout = 1'b0;
    @(negedge clk);
    check("held_stop", busy, 0);

    run_op(8'h20, 8'h03, 8'h23, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of SHIFT.
    start = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    check("arst_done", done, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("arst_nodone", done, 0);
    end
    rst_n = 1'b1;
    last_sum = 8'h00; last_cout = 1'b0;
    run_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
